// File: rtl/stream_out_pkg.sv
// Shared definitions for the stream_in / stream_out AXI-Stream edge blocks.
// Holds the frame FSM encoding, block partitioning and counter sizing helpers.
// No logic; every function is constant-foldable at elaboration.
package stream_out_pkg;

  // Frame FSM encoding shared by both stream edges
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Wide enough for any tstrb/tkeep in the design; users slice the low bits
  localparam int                    STRB_MAX_W     = 128;
  localparam logic [STRB_MAX_W-1:0] AXIS_STRB_ONES = '1;

  // Columns owned by each processing element (blocks do not overlap)
  function automatic int block_size(input int img_w, input int n_par);
    return img_w / n_par;
  endfunction

  // Counter width for a dimension; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// 2-entry AXI-Stream register slice carrying an opaque payload ({tuser, tlast, data}).
// Latency: 1 cycle from upstream handshake to dn_vld; 1 beat/cycle sustained.
// Backpressure: the skid entry absorbs the in-flight beat; up_rdy is a registered not-full flag.
module axis_skid_buf #(
  parameter int DW = 34
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_vld,
  output logic          up_rdy,
  input  logic [DW-1:0] up_dat,
  output logic          dn_vld,
  input  logic          dn_rdy,
  output logic [DW-1:0] dn_dat,
  output logic          empty
);

  logic          main_vld;
  logic [DW-1:0] main_dat;
  logic          skid_vld;
  logic [DW-1:0] skid_dat;

  // Ready depends only on registered state, so no tready-to-wready path exists
  assign up_rdy = ~skid_vld;
  assign dn_vld = main_vld;
  assign dn_dat = main_dat;
  assign empty  = ~main_vld & ~skid_vld;

  // Main entry refills from skid first, else from upstream; skid catches beats while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (dn_rdy || !main_vld) begin
      if (skid_vld) begin
        main_vld <= 1'b1;
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= up_vld;
        if (up_vld) main_dat <= up_dat;
      end
    end else if (up_vld && !skid_vld) begin
      skid_vld <= 1'b1;
      skid_dat <= up_dat;
    end
  end

endmodule

// File: rtl/stream_out.sv
// Raster-order AXI-Stream master merging N_PARALLEL upsp column blocks, VDMA framing (tuser=SOF, tlast=EOL).
// Latency: 1 cycle from element handshake to m_axis_tvalid; full throughput while tready=1.
// Backpressure: 2-entry skid; wready drops the cycle after the skid fills. STREAM_OUT_STALL_CNT_EN adds stall_cnt.
module stream_out
  import stream_out_pkg::*;
#(
  parameter int AXISOUT_DATA_WIDTH = 32,
  parameter int UPSP_WRDATA_WIDTH  = 32,
  parameter int DST_IMG_WIDTH      = 3840,
  parameter int DST_IMG_HEIGHT     = 2160,
  parameter int N_PARALLEL         = 2
) (
  input  logic                                    m_axis_aclk,
  input  logic                                    m_axis_arst,
  input  logic                                    UPSTART,
  input  logic [N_PARALLEL-1:0]                   upsp_ac_wvalid,
  input  logic [N_PARALLEL*UPSP_WRDATA_WIDTH-1:0] upsp_ac_wdata,
  output logic [N_PARALLEL-1:0]                   ac_upsp_wready,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic [AXISOUT_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [AXISOUT_DATA_WIDTH/8-1:0]         m_axis_tstrb,
  output logic [AXISOUT_DATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic                                    m_axis_tlast,
  output logic                                    m_axis_tuser,
  output logic                                    m_axis_tid,
  output logic                                    m_axis_tdest,
  output logic                                    ac_frame_done
`ifdef STREAM_OUT_STALL_CNT_EN
  ,
  output logic [31:0]                             stall_cnt
`endif
);

  localparam int BLOCK_SIZE = block_size(DST_IMG_WIDTH, N_PARALLEL);
  localparam int COL_W      = cnt_width(DST_IMG_WIDTH);
  localparam int ROW_W      = cnt_width(DST_IMG_HEIGHT);
  localparam int SEL_W      = cnt_width(N_PARALLEL);
  localparam int DW         = AXISOUT_DATA_WIDTH;
  localparam int STRB_W     = AXISOUT_DATA_WIDTH / 8;

  logic [1:0]       state;
  logic [COL_W-1:0] in_col;
  logic [ROW_W-1:0] in_row;
  logic [SEL_W-1:0] sel;
  logic             sel_vld;
  logic [DW-1:0]    sel_dat;
  logic             streaming;
  logic             up_vld;
  logic             up_rdy;
  logic             in_hs;
  logic             last_col;
  logic             last_row;
  logic             first_px;
  logic             buf_empty;
  logic [DW+1:0]    dn_dat;

  assign streaming = (state == ST_STREAM);
  assign last_col  = (in_col == COL_W'(DST_IMG_WIDTH - 1));
  assign last_row  = (in_row == ROW_W'(DST_IMG_HEIGHT - 1));
  assign first_px  = (in_col == '0) && (in_row == '0);

  // Owning element of the current column, found by a compare chain over block starts
  always_comb begin
    sel = '0;
    for (int j = 1; j < N_PARALLEL; j++) begin
      if (in_col >= COL_W'(j * BLOCK_SIZE)) sel = SEL_W'(j);
    end
  end

  // Mux the selected element's valid/data; unselected elements simply stall
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    for (int j = 0; j < N_PARALLEL; j++) begin
      if (sel == SEL_W'(j)) begin
        sel_vld = upsp_ac_wvalid[j];
        sel_dat = upsp_ac_wdata[j*UPSP_WRDATA_WIDTH +: UPSP_WRDATA_WIDTH];
      end
    end
  end

  // Only the selected element sees ready, and only while the skid has room
  always_comb begin
    ac_upsp_wready = '0;
    for (int j = 0; j < N_PARALLEL; j++) begin
      ac_upsp_wready[j] = streaming && (sel == SEL_W'(j)) && up_rdy;
    end
  end

  assign up_vld = streaming & sel_vld;
  assign in_hs  = up_vld & up_rdy;

  // Raster position advances once per accepted pixel and wraps to 0,0 after the frame
  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      in_col <= '0;
      in_row <= '0;
    end else if (in_hs) begin
      if (last_col) begin
        in_col <= '0;
        in_row <= last_row ? '0 : in_row + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
    end
  end

  // Frame sequencing: start on UPSTART, drain the skid after the last pixel, one done cycle
  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (UPSTART) state <= ST_STREAM;
        ST_STREAM: if (in_hs && last_col && last_row) state <= ST_DRAIN;
        ST_DRAIN:  if (buf_empty) state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_buf #(
    .DW (DW + 2)
  ) u_skid (
    .clk    (m_axis_aclk),
    .rst    (m_axis_arst),
    .up_vld (up_vld),
    .up_rdy (up_rdy),
    .up_dat ({first_px, last_col, sel_dat}),
    .dn_vld (m_axis_tvalid),
    .dn_rdy (m_axis_tready),
    .dn_dat (dn_dat),
    .empty  (buf_empty)
  );

  assign m_axis_tuser  = dn_dat[DW+1];
  assign m_axis_tlast  = dn_dat[DW];
  assign m_axis_tdata  = dn_dat[DW-1:0];
  assign m_axis_tstrb  = AXIS_STRB_ONES[STRB_W-1:0];
  assign m_axis_tkeep  = AXIS_STRB_ONES[STRB_W-1:0];
  assign m_axis_tid    = 1'b0;
  assign m_axis_tdest  = 1'b0;
  assign ac_frame_done = (state == ST_DONE);

`ifdef STREAM_OUT_STALL_CNT_EN
  // Saturating count of downstream stall cycles, restarted when a frame begins
  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && UPSTART) begin
      stall_cnt <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_out.sv
// Self-checking bench for stream_out on an 8x2 frame with two elements.
// Inputs change #1 after posedge, outputs are sampled on negedge.
// Expected beats come from a raster-order list built from the frame geometry.
module tb_stream_out;
  localparam int WI = 8;
  localparam int HI = 2;
  localparam int NP = 2;
  localparam int BS = WI / NP;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             upstart = 1'b0;
  logic             tready = 1'b1;
  logic [NP-1:0]    wvalid = '0;
  logic [NP*DW-1:0] wdata = '0;
  logic [NP-1:0]    wready;
  logic             tvalid, tlast, tuser, tid, tdest, done;
  logic [DW-1:0]    tdata;
  logic [DW/8-1:0]  tstrb, tkeep;
`ifdef STREAM_OUT_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  int          tests = 0;
  int          fails = 0;
  int          stall_m = 0;
  logic [7:0]  salt = 8'h00;
  logic [33:0] exp_q[$];
  int          er[NP];
  int          ec[NP];

  always #5 clk = ~clk;

  stream_out #(
    .AXISOUT_DATA_WIDTH (DW),
    .UPSP_WRDATA_WIDTH  (DW),
    .DST_IMG_WIDTH      (WI),
    .DST_IMG_HEIGHT     (HI),
    .N_PARALLEL         (NP)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_arst    (arst),
    .UPSTART        (upstart),
    .upsp_ac_wvalid (wvalid),
    .upsp_ac_wdata  (wdata),
    .ac_upsp_wready (wready),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tdata   (tdata),
    .m_axis_tstrb   (tstrb),
    .m_axis_tkeep   (tkeep),
    .m_axis_tlast   (tlast),
    .m_axis_tuser   (tuser),
    .m_axis_tid     (tid),
    .m_axis_tdest   (tdest),
    .ac_frame_done  (done)
`ifdef STREAM_OUT_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  function automatic logic [31:0] pix(input int r, input int c);
    return {salt, 16'h0000, 8'(r * 16 + c)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // mode 0: constant valid, 1: tready 1,0,0,1, 2: element 0 late, 3: random, 4: 3-cycle stall
  task automatic run_frame(input int mode, input int stray_cyc, input int rst_beat);
    int cyc = 0;
    int got = 0;
    int acc = 0;
    int dones = 0;
    int post = 0;
    int sel_e;
    logic prev_stall = 1'b0;
    logic prev_inhs = 1'b0;
    logic [33:0] prev_beat = '0;
    logic [33:0] e;
    logic [NP-1:0] hs;
    logic [NP-1:0] allow;
    salt = 8'($urandom_range(0, 255));
    exp_q.delete();
    for (int r = 0; r < HI; r++)
      for (int c = 0; c < WI; c++)
        exp_q.push_back({(r == 0 && c == 0), (c == WI - 1), pix(r, c)});
    for (int j = 0; j < NP; j++) begin
      er[j] = 0;
      ec[j] = 0;
    end
    @(posedge clk); #1;
    upstart = 1'b1; wvalid = '0; tready = 1'b1;
    @(posedge clk); #1;
    upstart = 1'b0;
    stall_m = 0;
    while (cyc < 600 && post < 3) begin
      for (int j = 0; j < NP; j++) begin
        logic v;
        v = (er[j] < HI);
        if (mode == 2 && j == 0 && cyc < 5) v = 1'b0;
        if (mode == 3 && $urandom_range(0, 3) == 0) v = 1'b0;
        wvalid[j] = v;
        wdata[j*DW +: DW] = pix(er[j] % HI, j * BS + ec[j]);
      end
      case (mode)
        1:       tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        3:       tready = ($urandom_range(0, 2) != 0);
        4:       tready = !(cyc >= 4 && cyc < 7);
        default: tready = 1'b1;
      endcase
      upstart = (cyc == stray_cyc);

      @(negedge clk);
      hs = wvalid & wready;
      sel_e = (acc % WI) / BS;
      allow = (acc < WI * HI) ? NP'(1 << sel_e) : '0;
      check("wready_sel", wready & ~allow, 0);
      if (prev_stall) check("hold", {tvalid, tuser, tlast, tdata}, {1'b1, prev_beat});
      if (prev_inhs) check("latency_vld", tvalid, 1);
      if (prev_stall && prev_inhs) check("skid_full_wready", wready, 0);
      if (mode == 2 && cyc < 5) check("blk_wait", acc, 0);
      if (tvalid && tready) begin
        check("beat_in_range", (got < WI * HI), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat", {tuser, tlast, tdata}, e);
        end
        got++;
      end
      if (done) begin
        dones++;
        check("done_after_last", got, WI * HI);
      end
`ifdef STREAM_OUT_STALL_CNT_EN
      check("stall_cnt", stall_cnt, stall_m);
      if (tvalid && !tready) stall_m++;
`endif
      if (dones > 0) begin
        post++;
        if (post > 1) check("idle_quiet", {tvalid, wready}, 0);
      end
      prev_stall = tvalid & ~tready;
      prev_inhs  = |hs;
      prev_beat  = {tuser, tlast, tdata};

      if (rst_beat > 0 && got == rst_beat) begin
        @(posedge clk); #1;
        arst = 1'b1;
        #1;
        check("rst_tvalid", tvalid, 0);
        check("rst_wready", wready, 0);
        check("rst_side", {tuser, tlast, tdata}, 0);
        stall_m = 0;
        @(posedge clk); #1;
        arst = 1'b0;
        wvalid = '0;
        return;
      end

      @(posedge clk); #1;
      for (int j = 0; j < NP; j++) begin
        if (hs[j]) begin
          ec[j]++;
          if (ec[j] == BS) begin
            ec[j] = 0;
            er[j]++;
          end
        end
      end
      acc += $countones(hs);
      cyc++;
    end
    check("done_once", dones, 1);
    check("beat_total", got, WI * HI);
`ifdef STREAM_OUT_STALL_CNT_EN
    if (mode == 4) check("stall_cnt_3", stall_cnt, 3);
`endif
  endtask

  initial begin
    @(negedge clk);
    check("rst_vals", {tvalid, wready, tlast, tuser, tdata, done}, 0);
    check("consts", {tstrb, tkeep, tid, tdest}, {8'hFF, 2'b00});
    @(posedge clk); #1;
    arst = 1'b0;
    @(negedge clk);
    check("idle_no_start", {tvalid, wready}, 0);

    run_frame(0, -1, 0);   // basic frame
    run_frame(1, -1, 0);   // 1,0,0,1 backpressure
    run_frame(2, -1, 0);   // block switching with late element 0
    run_frame(0, 6, 0);    // stray UPSTART mid-frame
    run_frame(0, -1, 0);   // next frame starts from IDLE
    run_frame(0, -1, 6);   // reset after beat 5
    run_frame(0, -1, 0);   // restart after reset
    for (int k = 0; k < 3; k++) run_frame(3, -1, 0);
    run_frame(4, -1, 0);   // three stall cycles
    run_frame(0, -1, 0);   // stall count restarts

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
